// File: rtl/enc_pkg.sv
// Shared types and helpers for the 4-to-2 request encoder.
// Holds the request width, the index width, the FSM state type and the index-to-one-hot helper.
package enc_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: first set bit of mask searching upward from ptr (mod 4),
// or the lowest set bit when rr_en=0.
module rr_pick4
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Fixed priority is the same search starting from index 0.
    assign base = rr_en ? ptr : '0;
    assign any  = |mask;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = base + IDX_W'(k);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_4to2.sv
// Sequential 4-to-2 request encoder: sticky pending mask, one grant at a time over valid/ready,
// round-robin (RR_EN=1) or fixed-priority (RR_EN=0) selection.
module req_encoder_4to2
    import enc_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    enc_state_t       state;
    enc_state_t       state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] idx_next;
    logic             hs;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] rem;
    logic [N_REQ-1:0] req_gated;
    logic [N_REQ-1:0] pending_next;
    logic             overflow_next;
    logic [IDX_W-1:0] idle_idx;
    logic             idle_any;
    logic [IDX_W-1:0] rem_idx;
    logic             rem_any;
    logic             rr_en;

    assign rr_en     = (RR_EN != 0);
    // out_valid comes straight from the state flop, so it is a registered output.
    assign out_valid = (state == HOLD);
    assign hs        = out_valid && out_ready;
    assign clr       = hs ? idx_to_onehot(out_idx) : '0;
    assign rem       = pending & ~clr;
    assign ptr_next  = hs ? out_idx + IDX_W'(1) : ptr;
    assign req_gated = req & {N_REQ{en}};

    // A re-request on the bit being cleared wins and does not count as overflow.
    assign pending_next  = rem | req_gated;
    assign overflow_next = |(req_gated & rem);

    rr_pick4 u_pick_idle (
        .mask  (pending),
        .ptr   (ptr),
        .rr_en (rr_en),
        .idx   (idle_idx),
        .any   (idle_any)
    );

    rr_pick4 u_pick_rem (
        .mask  (rem),
        .ptr   (ptr_next),
        .rr_en (rr_en),
        .idx   (rem_idx),
        .any   (rem_any)
    );

    always_comb begin
        state_next = state;
        idx_next   = out_idx;
        unique case (state)
            IDLE: begin
                if (idle_any) begin
                    idx_next   = idle_idx;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (rem_any) begin
                        idx_next = rem_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_idx  <= '0;
            ptr      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            out_idx  <= idx_next;
            ptr      <= ptr_next;
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: doc/req_encoder_4to2.md
# req_encoder_4to2

Sequential 4-to-2 request encoder: the reverse path to the 2-to-4 one-hot decoder. Up to four one-hot or multi-hot request lines are latched into a sticky pending mask and served one at a time as a 2-bit index over a valid/ready handshake. Arbitration between pending requests is round-robin or fixed-priority. It sits upstream of decoder-driven select logic, so a decoded line that fired can be turned back into an index.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  capture enable; gates `req` sampling only.
- `req`  in  4  request lines, sampled each cycle when `en`=1.
- `out_ready`  in  1  consumer accepts `out_idx` this cycle.
- `out_valid`  out  1  `out_idx` holds a granted request.
- `out_idx`  out  2  binary index of the granted request.
- `pending`  out  4  registered pending mask.
- `overflow`  out  1  one-cycle pulse: a request arrived on a bit already pending.

## Operation
- Capture rule:
  - `pending <= (pending & ~clr) | (req & {4{en}})`
  - `clr` = onehot(`out_idx`) when `out_valid && out_ready`, else 0.
- Same-bit clear and re-request in one cycle: the request wins and the bit stays pending. No overflow is raised in this case.
- Overflow: `overflow <= |(en & req & pending & ~clr)`. It is registered and non-sticky.
- `en`=0 blocks capture only. Already-pending requests keep draining.
- FSM has two states: `IDLE` and `HOLD`.
  - `IDLE`: `out_valid`=0. If `pending`≠0, load `out_idx` = pick(`pending`, `ptr`) and go to `HOLD`.
  - `HOLD`: `out_valid`=1, and `out_idx` is stable until handshake.
  - On handshake, let `rem` = `pending & ~clr`. If `rem`≠0, load pick(`rem`, `ptr_next`) and stay in `HOLD`. Otherwise go to `IDLE`.
  - Requests captured in the same cycle are not visible to the pick until the next cycle.
- Pick function:
  - `RR_EN`=1: search upward from `ptr`, modulo 4.
  - `RR_EN`=0: lowest set bit.
- Pointer update: on every handshake, `ptr_next` = `out_idx`+1 mod 4, so index 3 wraps to 0. `ptr` is unused when `RR_EN`=0.
- Full mask `4'b1111` with `RR_EN`=1 and `ptr`=0 drains in the order 0,1,2,3.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `pending`=0, `overflow`=0, `ptr`=0, state=`IDLE`. Reset is asynchronous: assertion clears everything immediately, even mid-handshake, and in-flight requests are lost.
- Latency:
  - `req` sampled at edge k sets `pending` after edge k.
  - `out_valid` rises after edge k+1, so there are 2 edges from `req` to `out_valid`.
- Throughput: one grant per cycle while `out_ready`=1 and requests remain.
- `out_ready` may be asserted before `out_valid`; it has no effect in `IDLE`.
- While `out_valid`=1 and `out_ready`=0, `out_idx` must not change, even if a higher-priority request arrives.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `enc_pkg` holds:
  - `N_REQ`=4 and `IDX_W`=2.
  - The `enc_state_t` enum {`IDLE`, `HOLD`}.
  - A function converting a 2-bit index to a 4-bit one-hot mask.
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: `mask[3:0]`, `ptr[1:0]`, `rr_en`.
  - Outputs: `idx[1:0]`, `any`.
  - It is reused by the `IDLE` pick and the `HOLD` re-pick.
- Top level holds the pending register, overflow logic, pointer, and FSM.

## Test plan
- Reset, then `en`=1 and a 1-cycle pulse `req`=`4'b0100`, with `out_ready`=1:
  - `pending`=`0100` after 1 edge.
  - `out_valid`=1 with `out_idx`=2 after 2 edges.
  - Next cycle: `pending`=0, `out_valid`=0.
- `RR_EN`=1, `req`=`4'b1111` for one cycle, `out_ready`=1: `out_idx` sequence 0,1,2,3 on consecutive cycles, then `out_valid`=0.
- `RR_EN`=0, `req`=`4'b1010`, `out_ready`=0 for 3 cycles:
  - `out_idx`=1 stays stable throughout.
  - Assert `req`=`0001` mid-hold: `out_idx` stays 1.
  - After release, the order is 1, 0, 3.
- `en`=0 with `req`=`4'b1111`: `pending` stays 0 and `out_valid` stays 0. Then `en`=1 for one cycle: all four are served.
- Overflow and same-cycle collision:
  - `pending[2]`=1, no handshake, `req[2]`=1: `overflow` pulses 1 for exactly one cycle.
  - Handshake on idx 2 with `req[2]`=1 in the same cycle: `pending[2]` stays 1 and `overflow`=0.
- Reset mid-operation: with `pending`=`0110`, `out_valid`=1, assert `rst` asynchronously between edges. All outputs go to 0 immediately, and `ptr`=0 after release.
